// File: rtl/alien_wave_ctrl_pkg.sv
// Shared parameters, state encoding and the shot-period helper for the
// enemy wave sequencer.
package alien_wave_ctrl_pkg;

  localparam int unsigned N_ALIENS           = 8;
  localparam int unsigned CLEAR_DELAY_FRAMES = 60;
  localparam int unsigned FIRE_PERIOD_FRAMES = 32;
  localparam int unsigned FIRE_PERIOD_MIN    = 4;
  localparam int unsigned MAX_LEVEL          = 15;

  localparam int unsigned SEL_W   = $clog2(N_ALIENS);
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned TIMER_W = $clog2(FIRE_PERIOD_FRAMES + 1);
  localparam int unsigned DELAY_W = $clog2(CLEAR_DELAY_FRAMES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SPAWN   = 3'd1,
    PLAY    = 3'd2,
    CLEARED = 3'd3,
    OVER    = 3'd4
  } wave_state_t;

  // Frames between shots for a given level: the base period shrinks by two
  // frames per level but never drops below the floor. The subtraction is
  // guarded so the unsigned result can never wrap.
  function automatic logic [TIMER_W-1:0] reload_value(input logic [LEVEL_W-1:0] lvl);
    int unsigned dec;
    dec = 32'(lvl) << 1;
    if (dec + FIRE_PERIOD_MIN >= FIRE_PERIOD_FRAMES)
      return TIMER_W'(FIRE_PERIOD_MIN);
    return TIMER_W'(FIRE_PERIOD_FRAMES - dec);
  endfunction

endpackage

// File: rtl/alien_wave_ctrl_if.sv
// Bus between the wave sequencer and the rest of the game: frame strobe,
// player/alien status in, respawn and fire commands plus HUD values out.
interface alien_wave_ctrl_if;
  import alien_wave_ctrl_pkg::*;

  logic               fsync;
  logic               start;
  logic [N_ALIENS-1:0] alien_alive;
  logic               alien_invaded;
  logic               bullet_busy;
  logic               wave_rst;
  logic               fire_req;
  logic [SEL_W-1:0]   fire_sel;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] speed;
  logic               game_over;
  logic [2:0]         state;

  modport master (
    input  fsync, start, alien_alive, alien_invaded, bullet_busy,
    output wave_rst, fire_req, fire_sel, level, speed, game_over, state
  );

  modport slave (
    output fsync, start, alien_alive, alien_invaded, bullet_busy,
    input  wave_rst, fire_req, fire_sel, level, speed, game_over, state
  );

endinterface

// File: rtl/alien_wave_ctrl_rr_alive_arbiter.sv
// Round-robin picker: finds the first living alien strictly after the
// pointer, wrapping around the formation. Purely combinational.
module rr_alive_arbiter
  import alien_wave_ctrl_pkg::*;
(
  input  logic [N_ALIENS-1:0] alive,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    next_idx,
  output logic                found
);

  // Scan from the farthest offset back to the nearest so the nearest living
  // alien after the pointer is the last one written and therefore wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx      = '0;
    next_idx = '0;
    found    = 1'b0;
    for (int off = N_ALIENS; off >= 1; off--) begin
      idx = SEL_W'((int'(ptr) + off) % N_ALIENS);
      if (alive[idx]) begin
        next_idx = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alien_wave_ctrl.sv
// Enemy wave sequencer: respawns the formation, tracks the level, paces
// enemy shots and picks the shooter round-robin among the living aliens.
module alien_wave_ctrl
  import alien_wave_ctrl_pkg::*;
(
  input  logic          pixel_clk,
  input  logic          rst_n,
  alien_wave_ctrl_if.master bus
);

  wave_state_t        state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic               wave_rst_q, wave_rst_d;
  logic               fire_req_q, fire_req_d;
  logic [SEL_W-1:0]   fire_sel_q, fire_sel_d;

  logic [SEL_W-1:0]   arb_idx;
  logic               arb_found;

  rr_alive_arbiter u_arb (
    .alive    (bus.alien_alive),
    .ptr      (ptr_q),
    .next_idx (arb_idx),
    .found    (arb_found)
  );

  // State and datapath registers; reset lands everything in a quiet idle.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      level_q    <= '0;
      timer_q    <= '0;
      ptr_q      <= SEL_W'(N_ALIENS - 1);
      delay_q    <= '0;
      wave_rst_q <= 1'b0;
      fire_req_q <= 1'b0;
      fire_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      ptr_q      <= ptr_d;
      delay_q    <= delay_d;
      wave_rst_q <= wave_rst_d;
      fire_req_q <= fire_req_d;
      fire_sel_q <= fire_sel_d;
    end
  end

  // Next-state logic: start edges are taken on any clock, everything in
  // PLAY and CLEARED waits for the frame strobe. A shot is only granted
  // when the wave neither ends nor is lost in the same frame.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    timer_d    = timer_q;
    ptr_d      = ptr_q;
    delay_d    = delay_q;
    wave_rst_d = 1'b0;
    fire_req_d = 1'b0;
    fire_sel_d = fire_sel_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          level_d    = LEVEL_W'(1);
          state_d    = SPAWN;
          wave_rst_d = 1'b1;
        end
      end

      SPAWN: begin
        state_d = PLAY;
        timer_d = reload_value(level_q);
        ptr_d   = SEL_W'(N_ALIENS - 1);
      end

      PLAY: begin
        if (bus.fsync) begin
          if (bus.alien_invaded) begin
            state_d = OVER;
          end else if (bus.alien_alive == '0) begin
            state_d = CLEARED;
            delay_d = DELAY_W'(CLEAR_DELAY_FRAMES - 1);
          end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (!bus.bullet_busy && arb_found) begin
            fire_req_d = 1'b1;
            fire_sel_d = arb_idx;
            ptr_d      = arb_idx;
            timer_d    = reload_value(level_q);
          end
        end
      end

      CLEARED: begin
        if (bus.fsync) begin
          if (delay_q == '0) begin
            if (level_q >= LEVEL_W'(MAX_LEVEL))
              level_d = LEVEL_W'(MAX_LEVEL);
            else
              level_d = level_q + 1'b1;
            state_d    = SPAWN;
            wave_rst_d = 1'b1;
          end else begin
            delay_d = delay_q - 1'b1;
          end
        end
      end

      OVER: begin
        if (bus.start) begin
          level_d    = LEVEL_W'(1);
          state_d    = SPAWN;
          wave_rst_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.wave_rst  = wave_rst_q;
  assign bus.fire_req  = fire_req_q;
  assign bus.fire_sel  = fire_sel_q;
  assign bus.level     = level_q;
  assign bus.speed     = level_q;
  assign bus.game_over = (state_q == OVER);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_alien_wave_ctrl.sv
// Directed bench for the enemy wave sequencer: start-up, shot pacing and
// rotation, sparse formations, busy bullet slot, level progression,
// game over and asynchronous reset.
module tb_alien_wave_ctrl;

  logic pixel_clk;
  logic rst_n;
  int   checks;
  int   errors;

  alien_wave_ctrl_if bus ();

  alien_wave_ctrl dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  // Free-running pixel clock, 10 time units per cycle.
  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // One game frame: two quiet cycles, then a single-cycle fsync. Returns at
  // the falling edge right after the fsync edge so the registered decision
  // for that frame is visible.
  task automatic frame();
    repeat (2) @(negedge pixel_clk);
    bus.fsync = 1'b1;
    @(negedge pixel_clk);
    bus.fsync = 1'b0;
  endtask

  // Run frames until a shot appears or the budget is spent; n is -1 on timeout.
  task automatic wait_fire(input int max_frames, output int n, output logic [2:0] sel);
    n   = -1;
    sel = 3'd0;
    for (int i = 1; i <= max_frames; i++) begin
      frame();
      if (bus.fire_req === 1'b1) begin
        n   = i;
        sel = bus.fire_sel;
        return;
      end
    end
  endtask

  // Empty the formation and run frames until the CLEARED pause ends.
  task automatic clear_wave(output int n);
    n = -1;
    bus.alien_alive = 8'h00;
    frame();
    for (int i = 1; i <= 100; i++) begin
      frame();
      if (bus.state !== 3'd3) begin
        n = i;
        break;
      end
    end
    bus.alien_alive = 8'hFF;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.state, bus.level, bus.speed, bus.wave_rst, bus.fire_req, bus.fire_sel, bus.game_over} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: got state=%0d level=%0d speed=%0d wave_rst=%0d fire_req=%0d fire_sel=%0d game_over=%0d want all 0",
               bus.state, bus.level, bus.speed, bus.wave_rst, bus.fire_req, bus.fire_sel, bus.game_over);
    end
    @(negedge pixel_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge pixel_clk);
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got state=%0d want 0", bus.state);
    end
  endtask

  task automatic test_start();
    bus.start = 1'b1;
    @(negedge pixel_clk);
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd1 || bus.wave_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_spawn: got state=%0d wave_rst=%0d want 1 1", bus.state, bus.wave_rst);
    end
    checks++;
    if (bus.level !== 4'd1 || bus.speed !== 4'd1) begin
      errors++;
      $display("[TB] FAIL start_level: got level=%0d speed=%0d want 1 1", bus.level, bus.speed);
    end
    @(negedge pixel_clk);
    checks++;
    if (bus.state !== 3'd2 || bus.wave_rst !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_play: got state=%0d wave_rst=%0d want 2 0", bus.state, bus.wave_rst);
    end
  endtask

  task automatic test_fire_rotation();
    int n;
    logic [2:0] sel;
    logic [2:0] exp_sel;
    bus.alien_alive = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_sel = 3'(k % 8);
      wait_fire(40, n, sel);
      checks++;
      if (n != 31 || sel !== exp_sel) begin
        errors++;
        $display("[TB] FAIL rotate_%0d: got frames=%0d sel=%0d want frames=31 sel=%0d", k, n, sel, exp_sel);
      end
    end
  endtask

  task automatic test_sparse_and_busy();
    int n;
    int fires;
    logic [2:0] sel;
    logic [2:0] exp_seq [3];
    exp_seq[0] = 3'd5;
    exp_seq[1] = 3'd7;
    exp_seq[2] = 3'd5;
    bus.alien_alive = 8'b1010_0000;
    for (int k = 0; k < 3; k++) begin
      wait_fire(40, n, sel);
      checks++;
      if (n != 31 || sel !== exp_seq[k]) begin
        errors++;
        $display("[TB] FAIL sparse_%0d: got frames=%0d sel=%0d want frames=31 sel=%0d", k, n, sel, exp_seq[k]);
      end
    end
    bus.bullet_busy = 1'b1;
    fires = 0;
    for (int i = 0; i < 40; i++) begin
      frame();
      if (bus.fire_req === 1'b1) fires++;
    end
    checks++;
    if (fires != 0) begin
      errors++;
      $display("[TB] FAIL busy_block: got %0d shots want 0", fires);
    end
    bus.bullet_busy = 1'b0;
    frame();
    checks++;
    if (bus.fire_req !== 1'b1 || bus.fire_sel !== 3'd7) begin
      errors++;
      $display("[TB] FAIL busy_release: got fire_req=%0d sel=%0d want 1 7", bus.fire_req, bus.fire_sel);
    end
  endtask

  task automatic test_clear_levels();
    int n;
    logic [2:0] sel;
    bus.alien_alive = 8'h00;
    frame();
    checks++;
    if (bus.state !== 3'd3 || bus.fire_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_enter: got state=%0d fire_req=%0d want 3 0", bus.state, bus.fire_req);
    end
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      frame();
      if (bus.state !== 3'd3) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != 60 || bus.state !== 3'd1 || bus.wave_rst !== 1'b1 || bus.level !== 4'd2) begin
      errors++;
      $display("[TB] FAIL clear_respawn: got frames=%0d state=%0d wave_rst=%0d level=%0d want 60 1 1 2",
               n, bus.state, bus.wave_rst, bus.level);
    end
    bus.alien_alive = 8'hFF;
    wait_fire(40, n, sel);
    checks++;
    if (n != 29 || sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL level2_reload: got frames=%0d sel=%0d want 29 0", n, sel);
    end
    for (int lvl = 3; lvl <= 16; lvl++) begin
      clear_wave(n);
      checks++;
      if (n != 60 || bus.level !== 4'((lvl > 15) ? 15 : lvl)) begin
        errors++;
        $display("[TB] FAIL level_step_%0d: got frames=%0d level=%0d want 60 %0d", lvl, n, bus.level, (lvl > 15) ? 15 : lvl);
      end
    end
    wait_fire(40, n, sel);
    checks++;
    if (n != 5 || sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL level15_reload: got frames=%0d sel=%0d want 5 0", n, sel);
    end
  endtask

  task automatic test_over();
    repeat (4) frame();
    bus.alien_invaded = 1'b1;
    bus.alien_alive   = 8'h00;
    frame();
    checks++;
    if (bus.state !== 3'd4 || bus.game_over !== 1'b1 || bus.fire_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL game_over: got state=%0d game_over=%0d fire_req=%0d want 4 1 0",
               bus.state, bus.game_over, bus.fire_req);
    end
    bus.alien_invaded = 1'b0;
    bus.alien_alive   = 8'hFF;
    repeat (3) frame();
    checks++;
    if (bus.state !== 3'd4) begin
      errors++;
      $display("[TB] FAIL over_hold: got state=%0d want 4", bus.state);
    end
    bus.start = 1'b1;
    @(negedge pixel_clk);
    bus.start = 1'b0;
    checks++;
    if (bus.state !== 3'd1 || bus.level !== 4'd1 || bus.game_over !== 1'b0 || bus.wave_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL over_restart: got state=%0d level=%0d game_over=%0d wave_rst=%0d want 1 1 0 1",
               bus.state, bus.level, bus.game_over, bus.wave_rst);
    end
    @(negedge pixel_clk);
  endtask

  task automatic test_async_reset();
    int n;
    logic [2:0] sel;
    bus.alien_alive = 8'h10;
    wait_fire(40, n, sel);
    checks++;
    if (n != 31 || sel !== 3'd4) begin
      errors++;
      $display("[TB] FAIL single_alien: got frames=%0d sel=%0d want 31 4", n, sel);
    end
    repeat (3) frame();
    @(posedge pixel_clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.state, bus.level, bus.speed, bus.wave_rst, bus.fire_req, bus.fire_sel, bus.game_over} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got state=%0d level=%0d speed=%0d wave_rst=%0d fire_req=%0d fire_sel=%0d game_over=%0d want all 0",
               bus.state, bus.level, bus.speed, bus.wave_rst, bus.fire_req, bus.fire_sel, bus.game_over);
    end
    @(negedge pixel_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge pixel_clk);
    checks++;
    if (bus.state !== 3'd0 || bus.level !== 4'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got state=%0d level=%0d want 0 0", bus.state, bus.level);
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst_n             = 1'b0;
    bus.fsync         = 1'b0;
    bus.start         = 1'b0;
    bus.alien_alive   = 8'hFF;
    bus.alien_invaded = 1'b0;
    bus.bullet_busy   = 1'b0;
    repeat (3) @(negedge pixel_clk);

    test_reset();
    test_start();
    test_fire_rotation();
    test_sparse_and_busy();
    test_clear_levels();
    test_over();
    test_async_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
